// File: rtl/cmd_frame_pkg.sv
// -----------------------------------------------------------------------------
// cmd_frame_pkg
// Shared types and constants for the command-frame receiver and its response
// transmitter.
//
// Build option:
//   CMD_FRAME_CHKSUM_EN - when defined, frames carry a fourth checksum byte
//                         and a bad checksum is answered with NAK.
// -----------------------------------------------------------------------------
package cmd_frame_pkg;

    // Receive FSM. CHK is only entered when the checksum option is built in.
    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW,
        CHK
    } rx_state_t;

    // Response transmit FSM.
    typedef enum logic {
        TX_IDLE,
        TX_WAIT
    } tx_state_t;

    localparam logic [7:0] POS_ACK = 8'hA5;
    localparam logic [7:0] NAK     = 8'hEE;

`ifdef CMD_FRAME_CHKSUM_EN
    localparam int FRAME_BYTES = 4;
`else
    localparam int FRAME_BYTES = 3;
`endif

    // Modulo-256 sum of a whole frame; a valid checksummed frame sums to 0.
    function automatic logic [7:0] frame_sum(input logic [7:0] c,
                                             input logic [7:0] h,
                                             input logic [7:0] l,
                                             input logic [7:0] k);
        return c + h + l + k;
    endfunction

endpackage

// File: rtl/resp_tx_ctrl.sv
// -----------------------------------------------------------------------------
// resp_tx_ctrl
// Hands single response bytes to the UART transmitter. A request is accepted
// only while idle; the byte is latched, trmt pulses once, and the block stays
// busy until the transmitter reports tx_done. Requests while busy are dropped.
//
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   send_req    - 1-cycle request to transmit req_byte
//   req_byte    - byte to send, sampled with send_req
//   tx_done     - transmitter finished the current byte
//   trmt        - 1-cycle start pulse to the transmitter
//   tx_data     - byte being transmitted, stable while busy
//   resp_busy   - a response is in flight
//   resp_sent   - 1-cycle pulse when the in-flight response completes
// -----------------------------------------------------------------------------
module resp_tx_ctrl
    import cmd_frame_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       send_req,
    input  logic [7:0] req_byte,
    input  logic       tx_done,
    output logic       trmt,
    output logic [7:0] tx_data,
    output logic       resp_busy,
    output logic       resp_sent
);

    tx_state_t  state_q, state_d;
    logic [7:0] tx_data_d;
    logic       trmt_d;
    logic       resp_sent_d;

    // NOTE: every variable gets a default before the case statement so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d     = state_q;
        tx_data_d   = tx_data;
        trmt_d      = 1'b0;
        resp_sent_d = 1'b0;
        case (state_q)
            TX_IDLE: begin
                if (send_req) begin
                    tx_data_d = req_byte;
                    trmt_d    = 1'b1;
                    state_d   = TX_WAIT;
                end
            end
            TX_WAIT: begin
                if (tx_done) begin
                    resp_sent_d = 1'b1;
                    state_d     = TX_IDLE;
                end
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update
    // together from values sampled at the same clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= TX_IDLE;
            tx_data   <= 8'h00;
            trmt      <= 1'b0;
            resp_sent <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_data   <= tx_data_d;
            trmt      <= trmt_d;
            resp_sent <= resp_sent_d;
        end
    end

    // Busy is decoded from the registered state, so it is glitch-free.
    assign resp_busy = (state_q == TX_WAIT);

endmodule

// File: rtl/cmd_frame_rcvr.sv
// -----------------------------------------------------------------------------
// cmd_frame_rcvr
// Assembles command frames (cmd, data_hi, data_lo[, chk]) from the wireless
// UART receiver, presents the last complete frame to the command processor,
// aborts partial frames whose bytes are spaced more than TIMEOUT_CYC cycles
// apart, and forwards single response bytes to the UART transmitter.
//
// Build option:
//   CMD_FRAME_CHKSUM_EN - 4-byte frames with a modulo-256 zero-sum checksum;
//                         a bad frame pulses frame_err and queues a NAK.
//
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   rx_rdy       - new received byte on rx_data (1-cycle pulse)
//   rx_data      - received byte
//   clr_cmd_rdy  - command processor consumed the frame
//   cmd_rdy      - cmd/data hold a complete, unconsumed frame
//   cmd, data    - command byte and {data_hi,data_lo} of last good frame
//   frame_err    - 1-cycle pulse on timeout abort (or bad checksum)
//   send_resp    - request to send resp
//   resp         - response byte
//   trmt         - 1-cycle start pulse to the UART transmitter
//   tx_data      - byte being transmitted
//   tx_done      - transmitter finished the byte
//   resp_busy    - response in flight
//   resp_sent    - 1-cycle pulse when a response completes
// -----------------------------------------------------------------------------
module cmd_frame_rcvr
    import cmd_frame_pkg::*;
#(
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_rdy,
    input  logic [7:0]  rx_data,
    input  logic        clr_cmd_rdy,
    output logic        cmd_rdy,
    output logic [7:0]  cmd,
    output logic [15:0] data,
    output logic        frame_err,
    input  logic        send_resp,
    input  logic [7:0]  resp,
    output logic        trmt,
    output logic [7:0]  tx_data,
    input  logic        tx_done,
    output logic        resp_busy,
    output logic        resp_sent
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    rx_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       cmd_sh_q, cmd_sh_d;
    logic [7:0]       hi_sh_q, hi_sh_d;
    logic [7:0]       lo_byte;
    logic             expire;
    logic             complete;
    logic             frame_err_d;
    logic             tx_req;
    logic [7:0]       tx_req_byte;

`ifdef CMD_FRAME_CHKSUM_EN
    logic [7:0] lo_sh_q, lo_sh_d;
    logic       chk_fail;
    assign lo_byte = lo_sh_q;
`else
    assign lo_byte = rx_data;
`endif

    // A byte arriving on the expiry cycle takes priority over the abort.
    assign expire = (state_q != IDLE) && !rx_rdy &&
                    (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    always_comb begin
        state_d     = state_q;
        cmd_sh_d    = cmd_sh_q;
        hi_sh_d     = hi_sh_q;
        complete    = 1'b0;
        frame_err_d = 1'b0;
`ifdef CMD_FRAME_CHKSUM_EN
        lo_sh_d     = lo_sh_q;
        chk_fail    = 1'b0;
`endif
        // Inter-byte gap counter: parked at 0 between frames.
        if (state_q == IDLE || rx_rdy) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (rx_rdy) begin
                    cmd_sh_d = rx_data;
                    state_d  = HIGH;
                end
            end
            HIGH: begin
                if (rx_rdy) begin
                    hi_sh_d = rx_data;
                    state_d = LOW;
                end else if (expire) begin
                    frame_err_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            LOW: begin
                if (rx_rdy) begin
`ifdef CMD_FRAME_CHKSUM_EN
                    lo_sh_d = rx_data;
                    state_d = CHK;
`else
                    complete = 1'b1;
                    state_d  = IDLE;
`endif
                end else if (expire) begin
                    frame_err_d = 1'b1;
                    state_d     = IDLE;
                end
            end
`ifdef CMD_FRAME_CHKSUM_EN
            CHK: begin
                if (rx_rdy) begin
                    state_d = IDLE;
                    if (frame_sum(cmd_sh_q, hi_sh_q, lo_sh_q, rx_data) == 8'h00) begin
                        complete = 1'b1;
                    end else begin
                        chk_fail    = 1'b1;
                        frame_err_d = 1'b1;
                    end
                end else if (expire) begin
                    frame_err_d = 1'b1;
                    state_d     = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            cmd_sh_q <= 8'h00;
            hi_sh_q  <= 8'h00;
`ifdef CMD_FRAME_CHKSUM_EN
            lo_sh_q  <= 8'h00;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cmd_sh_q <= cmd_sh_d;
            hi_sh_q  <= hi_sh_d;
`ifdef CMD_FRAME_CHKSUM_EN
            lo_sh_q  <= lo_sh_d;
`endif
        end
    end

    // Frame outputs only move on completion; completion beats a same-cycle
    // clear so a freshly delivered frame is never lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd       <= 8'h00;
            data      <= 16'h0000;
            cmd_rdy   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= frame_err_d;
            if (complete) begin
                cmd     <= cmd_sh_q;
                data    <= {hi_sh_q, lo_byte};
                cmd_rdy <= 1'b1;
            end else if (clr_cmd_rdy) begin
                cmd_rdy <= 1'b0;
            end
        end
    end

    // A checksum NAK takes the transmitter ahead of a coincident response.
`ifdef CMD_FRAME_CHKSUM_EN
    assign tx_req      = send_resp | chk_fail;
    assign tx_req_byte = chk_fail ? NAK : resp;
`else
    assign tx_req      = send_resp;
    assign tx_req_byte = resp;
`endif

    resp_tx_ctrl u_resp_tx_ctrl (
        .clk       (clk),
        .rst_n     (rst_n),
        .send_req  (tx_req),
        .req_byte  (tx_req_byte),
        .tx_done   (tx_done),
        .trmt      (trmt),
        .tx_data   (tx_data),
        .resp_busy (resp_busy),
        .resp_sent (resp_sent)
    );

endmodule

// File: tb/tb_cmd_frame_rcvr.sv
// -----------------------------------------------------------------------------
// tb_cmd_frame_rcvr
// Directed and randomized checks of cmd_frame_rcvr with a short timeout.
// The random phase keeps its own byte-stream model: a queue of the bytes of
// the frame in progress, emptied when a gap exceeds the timeout.
// -----------------------------------------------------------------------------
module tb_cmd_frame_rcvr;

    localparam int T = 64;
`ifdef CMD_FRAME_CHKSUM_EN
    localparam int NB = 4;
`else
    localparam int NB = 3;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx_rdy;
    logic [7:0]  rx_data;
    logic        clr_cmd_rdy;
    logic        cmd_rdy;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic        frame_err;
    logic        send_resp;
    logic [7:0]  resp;
    logic        trmt;
    logic [7:0]  tx_data;
    logic        tx_done;
    logic        resp_busy;
    logic        resp_sent;

    cmd_frame_rcvr #(.TIMEOUT_CYC(T)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_rdy      (rx_rdy),
        .rx_data     (rx_data),
        .clr_cmd_rdy (clr_cmd_rdy),
        .cmd_rdy     (cmd_rdy),
        .cmd         (cmd),
        .data        (data),
        .frame_err   (frame_err),
        .send_resp   (send_resp),
        .resp        (resp),
        .trmt        (trmt),
        .tx_data     (tx_data),
        .tx_done     (tx_done),
        .resp_busy   (resp_busy),
        .resp_sent   (resp_sent)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int err_cnt = 0;
    int trmt_cnt = 0;
    int sent_cnt = 0;
    int exp_err = 0;
    int exp_trmt = 0;
    int exp_sent = 0;

    // Pulse counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (frame_err === 1'b1) err_cnt++;
        if (trmt === 1'b1) trmt_cnt++;
        if (resp_sent === 1'b1) sent_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic clr);
        rx_rdy      = 1'b1;
        rx_data     = b;
        clr_cmd_rdy = clr;
        tick();
        rx_rdy      = 1'b0;
        rx_data     = 8'h00;
        clr_cmd_rdy = 1'b0;
    endtask

    // Whole valid frame, bytes `gap` cycles apart; checksum added when built in.
    task automatic send_frame(input logic [7:0] c, input logic [7:0] h,
                              input logic [7:0] l, input int gap, input logic clr_last);
        logic [7:0] s;
        s = c + h + l;
        send_byte(c, 1'b0);
        idle(gap - 1);
        send_byte(h, 1'b0);
        idle(gap - 1);
`ifdef CMD_FRAME_CHKSUM_EN
        send_byte(l, 1'b0);
        idle(gap - 1);
        send_byte(-s, clr_last);
`else
        send_byte(l, clr_last);
`endif
    endtask

    task automatic clear_rdy();
        clr_cmd_rdy = 1'b1;
        tick();
        clr_cmd_rdy = 1'b0;
    endtask

    task automatic pulse_tx_done();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
    endtask

    logic [7:0]  part[$];
    logic [7:0]  exp_cmd;
    logic [15:0] exp_data;
    logic        exp_rdy;
    logic        exp_busy;

    initial begin
        rst_n = 1'b0; rx_rdy = 1'b0; rx_data = 8'h00; clr_cmd_rdy = 1'b0;
        send_resp = 1'b0; resp = 8'h00; tx_done = 1'b0;

        // ---- reset state ----
        #3;
        check("rst_cmd_rdy", cmd_rdy, 0);
        check("rst_cmd", cmd, 0);
        check("rst_data", data, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_trmt", trmt, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_resp_busy", resp_busy, 0);
        check("rst_resp_sent", resp_sent, 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        idle(2);

        // ---- basic frame, bytes 50 cycles apart ----
        send_byte(8'h05, 1'b0); idle(49);
        send_byte(8'h01, 1'b0); idle(49);
`ifdef CMD_FRAME_CHKSUM_EN
        send_byte(8'hFF, 1'b0); idle(49);
        check("f1_rdy_before_last", cmd_rdy, 0);
        send_byte(8'hFB, 1'b0);
`else
        check("f1_rdy_before_last", cmd_rdy, 0);
        send_byte(8'hFF, 1'b0);
`endif
        check("f1_cmd_rdy", cmd_rdy, 1);
        check("f1_cmd", cmd, 8'h05);
        check("f1_data", data, 16'h01FF);
        clear_rdy();
        check("f1_clr_rdy", cmd_rdy, 0);
        check("f1_cmd_held", cmd, 8'h05);

        // ---- timeout abort after two bytes ----
        send_byte(8'h02, 1'b0); idle(49);
        send_byte(8'h40, 1'b0); idle(T + 5);
        exp_err++;
        check("to_err_count", err_cnt, exp_err);
        check("to_cmd_held", cmd, 8'h05);
        check("to_data_held", data, 16'h01FF);
        check("to_cmd_rdy", cmd_rdy, 0);
        send_frame(8'h02, 8'h40, 8'h00, 10, 1'b0);
        check("to_next_rdy", cmd_rdy, 1);
        check("to_next_cmd", cmd, 8'h02);
        check("to_next_data", data, 16'h4000);
        clear_rdy();

        // ---- bytes exactly on the expiry cycle ----
        send_frame(8'h11, 8'h22, 8'h33, T, 1'b0);
        idle(2);
        check("exp_no_err", err_cnt, exp_err);
        check("exp_rdy", cmd_rdy, 1);
        check("exp_cmd", cmd, 8'h11);
        check("exp_data", data, 16'h2233);

        // ---- completion coincides with clear: set wins, values overwrite ----
        send_frame(8'h44, 8'h55, 8'h66, 3, 1'b1);
        check("sc_rdy", cmd_rdy, 1);
        check("sc_cmd", cmd, 8'h44);
        check("sc_data", data, 16'h5566);
        clear_rdy();
        check("sc_clr", cmd_rdy, 0);

        // ---- response transmit ----
        resp = 8'hA5; send_resp = 1'b1;
        tick();
        send_resp = 1'b0; resp = 8'h00;
        exp_trmt++;
        check("tx_trmt", trmt, 1);
        check("tx_data_a5", tx_data, 8'hA5);
        check("tx_busy", resp_busy, 1);
        tick();
        check("tx_trmt_once", trmt, 0);
        resp = 8'h00; send_resp = 1'b1;
        tick();
        send_resp = 1'b0;
        check("tx_ignored_data", tx_data, 8'hA5);
        check("tx_ignored_busy", resp_busy, 1);
        send_frame(8'h77, 8'h88, 8'h99, 4, 1'b0);
        check("tx_rx_overlap_cmd", cmd, 8'h77);
        check("tx_rx_overlap_data", data, 16'h8899);
        idle(2);
        check("tx_trmt_count", trmt_cnt, exp_trmt);
        pulse_tx_done();
        exp_sent++;
        check("tx_sent", resp_sent, 1);
        check("tx_idle", resp_busy, 0);
        tick();
        check("tx_sent_once", resp_sent, 0);
        check("tx_sent_count", sent_cnt, exp_sent);
        clear_rdy();

`ifdef CMD_FRAME_CHKSUM_EN
        // ---- checksum mismatch answers with NAK ----
        send_byte(8'h05, 1'b0); idle(4);
        send_byte(8'h01, 1'b0); idle(4);
        send_byte(8'hFF, 1'b0); idle(4);
        send_byte(8'h00, 1'b0);
        exp_err++; exp_trmt++;
        check("chk_trmt", trmt, 1);
        check("chk_nak", tx_data, 8'hEE);
        check("chk_busy", resp_busy, 1);
        check("chk_no_rdy", cmd_rdy, 0);
        tick();
        check("chk_err_count", err_cnt, exp_err);
        pulse_tx_done();
        exp_sent++;
        send_frame(8'h05, 8'h01, 8'hFF, 4, 1'b0);
        check("chk_good_rdy", cmd_rdy, 1);
        check("chk_good_data", data, 16'h01FF);
        clear_rdy();
`endif

        // ---- randomized byte stream against the queue model ----
        exp_cmd  = cmd_frame_expected_cmd();
        exp_data = cmd_frame_expected_data();
        exp_rdy  = 1'b0;
        exp_busy = 1'b0;
        idle(2);
        for (int i = 0; i < 80; i++) begin
            int         r;
            int         g;
            logic [7:0] b;
            logic [7:0] s;
            r = int'($urandom_range(0, 9));
            if (r < 2)       g = T;
            else if (r == 2) g = T + 1;
            else if (r == 3) g = 1;
            else             g = int'($urandom_range(2, T / 2));
            b = 8'($urandom);
`ifdef CMD_FRAME_CHKSUM_EN
            if (part.size() == 3 && $urandom_range(0, 1) == 1) begin
                s = part[0] + part[1] + part[2];
                b = -s;
            end
`endif
            if (part.size() > 0 && g > T) begin
                part.delete();
                exp_err++;
            end
            idle(g - 1);
            send_byte(b, 1'b0);
            part.push_back(b);
            if (part.size() == NB) begin
                s = 8'h00;
                foreach (part[k]) s = s + part[k];
`ifdef CMD_FRAME_CHKSUM_EN
                if (s != 8'h00) begin
                    exp_err++;
                    if (!exp_busy) begin
                        exp_busy = 1'b1;
                        exp_trmt++;
                        check("rnd_nak", tx_data, 8'hEE);
                    end
                end else begin
                    exp_cmd  = part[0];
                    exp_data = {part[1], part[2]};
                    exp_rdy  = 1'b1;
                end
`else
                exp_cmd  = part[0];
                exp_data = {part[1], part[2]};
                exp_rdy  = 1'b1;
`endif
                part.delete();
            end
            check("rnd_cmd", cmd, exp_cmd);
            check("rnd_data", data, exp_data);
            check("rnd_rdy", cmd_rdy, exp_rdy);
            if (part.size() == 0 && exp_rdy && $urandom_range(0, 3) == 0) begin
                clear_rdy();
                exp_rdy = 1'b0;
                check("rnd_clr", cmd_rdy, 0);
            end
        end
        idle(T + 5);
        if (part.size() > 0) begin
            part.delete();
            exp_err++;
        end
        check("rnd_err_count", err_cnt, exp_err);
        check("rnd_trmt_count", trmt_cnt, exp_trmt);
        check("rnd_busy", resp_busy, exp_busy);
        if (exp_busy) begin
            pulse_tx_done();
            exp_sent++;
            exp_busy = 1'b0;
        end

        // ---- reset mid-frame and mid-transmit ----
        resp = 8'hA5; send_resp = 1'b1;
        tick();
        send_resp = 1'b0;
        exp_trmt++;
        send_byte(8'h3C, 1'b0); idle(3);
        send_byte(8'h5A, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("mr_cmd_rdy", cmd_rdy, 0);
        check("mr_cmd", cmd, 0);
        check("mr_data", data, 0);
        check("mr_frame_err", frame_err, 0);
        check("mr_trmt", trmt, 0);
        check("mr_tx_data", tx_data, 0);
        check("mr_resp_busy", resp_busy, 0);
        check("mr_resp_sent", resp_sent, 0);
        idle(2);
        rst_n = 1'b1;
        idle(2);
        send_frame(8'h9A, 8'hBC, 8'hDE, 5, 1'b0);
        check("mr_after_rdy", cmd_rdy, 1);
        check("mr_after_cmd", cmd, 8'h9A);
        check("mr_after_data", data, 16'hBCDE);
        idle(T + 5);
        check("mr_err_count", err_cnt, exp_err);
        check("mr_trmt_count", trmt_cnt, exp_trmt);
        check("mr_sent_count", sent_cnt, exp_sent);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Values of the last good frame delivered by the directed steps, which
    // seed the random-phase model.
    function automatic logic [7:0] cmd_frame_expected_cmd();
`ifdef CMD_FRAME_CHKSUM_EN
        return 8'h05;
`else
        return 8'h77;
`endif
    endfunction

    function automatic logic [15:0] cmd_frame_expected_data();
`ifdef CMD_FRAME_CHKSUM_EN
        return 16'h01FF;
`else
        return 16'h8899;
`endif
    endfunction

endmodule
